// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants and types for the ID/EX operand stage.
// Also provides the forward-select encoding that the top exports for debug.
package id_ex_operand_stage_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_operand_forward_mux.sv
// Combinational operand resolver for one source register.
// Priority: x0, then MEM result, then WB result, then register file data.
module operand_forward_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [REG_IDX_W-1:0] i_index,
  input  logic                 i_mem_wb_en,
  input  logic [REG_IDX_W-1:0] i_mem_rd_index,
  input  logic [W-1:0]         i_mem_fwd_data,
  input  logic                 i_wb_en,
  input  logic [REG_IDX_W-1:0] i_wb_rd_index,
  input  logic [W-1:0]         i_wb_data,
  input  logic [W-1:0]         i_rf_data,
  output logic [W-1:0]         o_data,
  output fwd_sel_e             o_sel
);

  // WB still needs forwarding: the register file has no same-cycle write-through.
  always_comb begin
    o_sel  = FWD_RF;
    o_data = i_rf_data;
    if (i_index == ZERO_REG) begin
      o_sel  = FWD_ZERO;
      o_data = '0;
    end else if (i_mem_wb_en && (i_mem_rd_index == i_index)) begin
      o_sel  = FWD_MEM;
      o_data = i_mem_fwd_data;
    end else if (i_wb_en && (i_wb_rd_index == i_index)) begin
      o_sel  = FWD_WB;
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand fetch, forwarding, load-use bubble insertion and the ID/EX register.
// Precedence on each edge: reset, flush, hold, load-use bubble, normal issue.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_id_valid,
  input  logic [XLEN-1:0]      i_id_pc,
  input  logic [REG_IDX_W-1:0] i_id_rs1_index,
  input  logic [REG_IDX_W-1:0] i_id_rs2_index,
  input  logic                 i_id_uses_rs1,
  input  logic                 i_id_uses_rs2,
  input  logic [REG_IDX_W-1:0] i_id_rd_index,
  input  logic                 i_id_is_load,
  input  logic [CTRL_W-1:0]    i_id_ctrl,
  output logic [REG_IDX_W-1:0] o_rf_rs1_index,
  output logic [REG_IDX_W-1:0] o_rf_rs2_index,
  input  logic [XLEN-1:0]      i_rf_rs1_data,
  input  logic [XLEN-1:0]      i_rf_rs2_data,
  input  logic                 i_mem_wb_en,
  input  logic [REG_IDX_W-1:0] i_mem_rd_index,
  input  logic [XLEN-1:0]      i_mem_fwd_data,
  input  logic                 i_wb_en,
  input  logic [REG_IDX_W-1:0] i_wb_rd_index,
  input  logic [XLEN-1:0]      i_wb_data,
  input  logic                 i_ex_hold,
  input  logic                 i_ex_flush,
  output logic                 o_id_stall,
  output logic                 o_ex_valid,
  output logic [XLEN-1:0]      o_ex_pc,
  output logic [XLEN-1:0]      o_ex_rs1_data,
  output logic [XLEN-1:0]      o_ex_rs2_data,
  output logic [REG_IDX_W-1:0] o_ex_rd_index,
  output logic                 o_ex_is_load,
  output logic [CTRL_W-1:0]    o_ex_ctrl,
  output logic [CNT_W-1:0]     o_stall_cycles,
  output fwd_sel_e             o_rs1_fwd_sel,
  output fwd_sel_e             o_rs2_fwd_sel
);

  logic [XLEN-1:0]      w_rs1_data;
  logic [XLEN-1:0]      w_rs2_data;
  logic                 w_lu;
  logic                 w_rs1_match;
  logic                 w_rs2_match;

  logic                 r_ex_valid;
  logic [XLEN-1:0]      r_ex_pc;
  logic [XLEN-1:0]      r_ex_rs1_data;
  logic [XLEN-1:0]      r_ex_rs2_data;
  logic [REG_IDX_W-1:0] r_ex_rd_index;
  logic                 r_ex_is_load;
  logic [CTRL_W-1:0]    r_ex_ctrl;
  logic [CNT_W-1:0]     r_stall_cycles;

  assign o_rf_rs1_index = i_id_rs1_index;
  assign o_rf_rs2_index = i_id_rs2_index;

  operand_forward_mux #(.W(XLEN)) u_fwd_rs1 (
    .i_index        (i_id_rs1_index),
    .i_mem_wb_en    (i_mem_wb_en),
    .i_mem_rd_index (i_mem_rd_index),
    .i_mem_fwd_data (i_mem_fwd_data),
    .i_wb_en        (i_wb_en),
    .i_wb_rd_index  (i_wb_rd_index),
    .i_wb_data      (i_wb_data),
    .i_rf_data      (i_rf_rs1_data),
    .o_data         (w_rs1_data),
    .o_sel          (o_rs1_fwd_sel)
  );

  operand_forward_mux #(.W(XLEN)) u_fwd_rs2 (
    .i_index        (i_id_rs2_index),
    .i_mem_wb_en    (i_mem_wb_en),
    .i_mem_rd_index (i_mem_rd_index),
    .i_mem_fwd_data (i_mem_fwd_data),
    .i_wb_en        (i_wb_en),
    .i_wb_rd_index  (i_wb_rd_index),
    .i_wb_data      (i_wb_data),
    .i_rf_data      (i_rf_rs2_data),
    .o_data         (w_rs2_data),
    .o_sel          (o_rs2_fwd_sel)
  );

  // Load data only exists in MEM, so a dependent instruction must wait one cycle.
  assign w_rs1_match = i_id_uses_rs1 && (i_id_rs1_index == r_ex_rd_index);
  assign w_rs2_match = i_id_uses_rs2 && (i_id_rs2_index == r_ex_rd_index);
  assign w_lu = r_ex_valid && r_ex_is_load && (r_ex_rd_index != ZERO_REG) &&
                i_id_valid && (w_rs1_match || w_rs2_match);

  // A flush makes the ID instruction wrong-path, so it is never held.
  assign o_id_stall = !i_ex_flush && (i_ex_hold || w_lu);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_rs1_data  <= '0;
      r_ex_rs2_data  <= '0;
      r_ex_rd_index  <= '0;
      r_ex_is_load   <= 1'b0;
      r_ex_ctrl      <= '0;
      r_stall_cycles <= '0;
    end else if (i_ex_flush) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_rs1_data  <= '0;
      r_ex_rs2_data  <= '0;
      r_ex_rd_index  <= '0;
      r_ex_is_load   <= 1'b0;
      r_ex_ctrl      <= '0;
    end else if (!i_ex_hold) begin
      if (w_lu) begin
        r_ex_valid     <= 1'b0;
        r_ex_pc        <= '0;
        r_ex_rs1_data  <= '0;
        r_ex_rs2_data  <= '0;
        r_ex_rd_index  <= '0;
        r_ex_is_load   <= 1'b0;
        r_ex_ctrl      <= '0;
        if (r_stall_cycles != '1) begin
          r_stall_cycles <= r_stall_cycles + 1'b1;
        end
      end else begin
        r_ex_valid    <= i_id_valid;
        r_ex_pc       <= i_id_pc;
        r_ex_rs1_data <= w_rs1_data;
        r_ex_rs2_data <= w_rs2_data;
        r_ex_rd_index <= i_id_rd_index;
        r_ex_is_load  <= i_id_is_load;
        r_ex_ctrl     <= i_id_ctrl;
      end
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_pc        = r_ex_pc;
  assign o_ex_rs1_data  = r_ex_rs1_data;
  assign o_ex_rs2_data  = r_ex_rs2_data;
  assign o_ex_rd_index  = r_ex_rd_index;
  assign o_ex_is_load   = r_ex_is_load;
  assign o_ex_ctrl      = r_ex_ctrl;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed scenarios then random traffic.
// Accepted ID instructions push expected EX entries; a monitor pops and compares.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        isLoad;
    logic [15:0] ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid;
  logic [31:0] idPc;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, isLoad;
  logic [15:0] ctrl;
  logic [4:0]  rfRs1Index, rfRs2Index;
  logic [31:0] rfRs1Data, rfRs2Data;
  logic        memEn;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        hold, flush;
  logic        idStall, exValid, exIsLoad;
  logic [31:0] exPc, exRs1, exRs2, stallCycles;
  logic [4:0]  exRd;
  logic [15:0] exCtrl;
  fwd_sel_e    sel1, sel2;

  logic [31:0] regs [32];
  exp_t        sbQ [$];
  exp_t        cur;
  int          total = 0;
  int          bad   = 0;

  logic        mV, mLoad, lastStall;
  logic [4:0]  mRd;
  logic [31:0] mCnt;
  logic        wasHold;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_valid(idValid), .i_id_pc(idPc),
    .i_id_rs1_index(rs1), .i_id_rs2_index(rs2),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
    .i_id_rd_index(rd), .i_id_is_load(isLoad), .i_id_ctrl(ctrl),
    .o_rf_rs1_index(rfRs1Index), .o_rf_rs2_index(rfRs2Index),
    .i_rf_rs1_data(rfRs1Data), .i_rf_rs2_data(rfRs2Data),
    .i_mem_wb_en(memEn), .i_mem_rd_index(memRd), .i_mem_fwd_data(memData),
    .i_wb_en(wbEn), .i_wb_rd_index(wbRd), .i_wb_data(wbData),
    .i_ex_hold(hold), .i_ex_flush(flush),
    .o_id_stall(idStall), .o_ex_valid(exValid), .o_ex_pc(exPc),
    .o_ex_rs1_data(exRs1), .o_ex_rs2_data(exRs2), .o_ex_rd_index(exRd),
    .o_ex_is_load(exIsLoad), .o_ex_ctrl(exCtrl), .o_stall_cycles(stallCycles),
    .o_rs1_fwd_sel(sel1), .o_rs2_fwd_sel(sel2)
  );

  // Register file model: writes land at the clock edge, no write-through.
  assign rfRs1Data = regs[rfRs1Index];
  assign rfRs2Data = regs[rfRs2Index];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wbEn && wbRd != 5'd0) begin
      regs[wbRd] <= wbData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwdVal(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (memEn && memRd == idx) return memData;
    if (wbEn && wbRd == idx) return wbData;
    return regs[idx];
  endfunction

  function automatic logic [1:0] fwdSel(input logic [4:0] idx);
    if (idx == 5'd0) return FWD_ZERO;
    if (memEn && memRd == idx) return FWD_MEM;
    if (wbEn && wbRd == idx) return FWD_WB;
    return FWD_RF;
  endfunction

  // One clock cycle with the current input variables; called at posedge+1, returns at posedge+1.
  task automatic applyStimulus();
    logic lu, expStall;
    exp_t e;
    checkOutput("exValid", {31'd0, exValid}, {31'd0, mV});
    checkOutput("stallCnt", stallCycles, mCnt);
    #1;
    checkOutput("rfIdx1", {27'd0, rfRs1Index}, {27'd0, rs1});
    checkOutput("rfIdx2", {27'd0, rfRs2Index}, {27'd0, rs2});
    checkOutput("sel1", {30'd0, sel1}, {30'd0, fwdSel(rs1)});
    checkOutput("sel2", {30'd0, sel2}, {30'd0, fwdSel(rs2)});
    lu = mV && mLoad && (mRd != 5'd0) && idValid &&
         ((u1 && rs1 == mRd) || (u2 && rs2 == mRd));
    expStall = !flush && (hold || lu);
    checkOutput("idStall", {31'd0, idStall}, {31'd0, expStall});
    lastStall = expStall;
    e = '{pc: idPc, rs1: fwdVal(rs1), rs2: fwdVal(rs2), rd: rd, isLoad: isLoad, ctrl: ctrl};
    @(posedge clk);
    if (rst) begin
      mV = 0; mLoad = 0; mRd = 0; mCnt = 0;
    end else if (flush) begin
      mV = 0;
    end else if (!hold) begin
      if (lu) begin
        mV = 0; mLoad = 0;
        if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      end else begin
        mV = idValid; mRd = rd; mLoad = isLoad;
        if (idValid) sbQ.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; idValid = 0; hold = 0; flush = 0; memEn = 0; wbEn = 0;
    u1 = 0; u2 = 0; isLoad = 0;
  endtask

  task automatic setId(input logic [31:0] pc, input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic [4:0] d,
                       input logic ld, input logic [15:0] c);
    idValid = 1; idPc = pc; rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; isLoad = ld; ctrl = c;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] val);
    idle(); wbEn = 1; wbRd = idx; wbData = val;
    applyStimulus();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, exValid}, 32'd0);
    checkOutput({tag, "_pc"}, exPc, 32'd0);
    checkOutput({tag, "_rs1"}, exRs1, 32'd0);
    checkOutput({tag, "_rs2"}, exRs2, 32'd0);
    checkOutput({tag, "_rd"}, {27'd0, exRd}, 32'd0);
    checkOutput({tag, "_load"}, {31'd0, exIsLoad}, 32'd0);
    checkOutput({tag, "_ctrl"}, {16'd0, exCtrl}, 32'd0);
    checkOutput({tag, "_cnt"}, stallCycles, 32'd0);
    checkOutput({tag, "_stall"}, {31'd0, idStall}, 32'd0);
  endtask

  // Monitor: a new EX entry is popped and compared; a held entry must still match.
  initial begin
    forever begin
      @(posedge clk);
      wasHold = hold && !flush && !rst;
      #1;
      if (exValid) begin
        if (!wasHold) begin
          checkOutput("sbHasEntry", {31'd0, sbQ.size() > 0}, 32'd1);
          if (sbQ.size() > 0) cur = sbQ.pop_front();
        end
        checkOutput("exPc", exPc, cur.pc);
        checkOutput("exRs1", exRs1, cur.rs1);
        checkOutput("exRs2", exRs2, cur.rs2);
        checkOutput("exRd", {27'd0, exRd}, {27'd0, cur.rd});
        checkOutput("exIsLoad", {31'd0, exIsLoad}, {31'd0, cur.isLoad});
        checkOutput("exCtrl", {16'd0, exCtrl}, {16'd0, cur.ctrl});
      end
    end
  end

  initial begin
    idle(); rst = 1;
    idPc = 0; rs1 = 0; rs2 = 0; rd = 0; ctrl = 0;
    memRd = 0; memData = 0; wbRd = 0; wbData = 0;
    mV = 0; mLoad = 0; mRd = 0; mCnt = 0; lastStall = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus();
    checkAllZero("reset");
    idle();

    writeReg(5, 32'h11);
    writeReg(6, 32'h22);
    idle();

    // No-hazard issue
    setId(32'h100, 5, 6, 1, 1, 7, 0, 16'h1234);
    applyStimulus();
    checkOutput("noHaz_valid", {31'd0, exValid}, 32'd1);
    checkOutput("noHaz_rs1", exRs1, 32'h11);
    checkOutput("noHaz_rs2", exRs2, 32'h22);

    // Forwarding priority: MEM over WB over RF
    setId(32'h104, 3, 0, 1, 0, 8, 0, 16'h0);
    memEn = 1; memRd = 3; memData = 32'hAAAA;
    wbEn = 1; wbRd = 3; wbData = 32'hBBBB;
    applyStimulus();
    checkOutput("fwd_mem", exRs1, 32'hAAAA);
    memEn = 0;
    applyStimulus();
    checkOutput("fwd_wb", exRs1, 32'hBBBB);
    writeReg(3, 32'hCCCC);
    setId(32'h108, 3, 0, 1, 0, 8, 0, 16'h0);
    applyStimulus();
    checkOutput("fwd_rf", exRs1, 32'hCCCC);

    // x0 is never forwarded
    idle();
    setId(32'h10C, 5, 0, 1, 1, 8, 0, 16'h0);
    memEn = 1; memRd = 0; memData = 32'hFFFF;
    applyStimulus();
    checkOutput("x0_rs2", exRs2, 32'h0);

    // Load-use: one bubble, then the load result comes from MEM
    idle();
    setId(32'h120, 1, 2, 0, 0, 4, 1, 16'h0);
    applyStimulus();
    setId(32'h124, 4, 0, 1, 0, 9, 0, 16'h55);
    applyStimulus();
    checkOutput("lu_bubble", {31'd0, exValid}, 32'd0);
    checkOutput("lu_cnt", stallCycles, 32'd1);
    memEn = 1; memRd = 4; memData = 32'h4444;
    applyStimulus();
    checkOutput("lu_fwd", exRs1, 32'h4444);

    // No stall for rd=0 or an unused source
    idle();
    setId(32'h130, 1, 2, 0, 0, 0, 1, 16'h0);
    applyStimulus();
    setId(32'h134, 0, 0, 1, 1, 9, 0, 16'h0);
    #1 checkOutput("lu_rd0", {31'd0, idStall}, 32'd0);
    setId(32'h138, 1, 2, 0, 0, 4, 1, 16'h0);
    applyStimulus();
    applyStimulus();
    setId(32'h13C, 4, 1, 0, 1, 9, 0, 16'h0);
    #1 checkOutput("lu_unused", {31'd0, idStall}, 32'd0);
    applyStimulus();

    // Hold freezes the EX entry for three cycles
    setId(32'h140, 5, 6, 1, 1, 7, 0, 16'h77);
    applyStimulus();
    setId(32'h144, 5, 6, 1, 1, 8, 0, 16'h88);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("hold_pc", exPc, 32'h140);
      checkOutput("hold_valid", {31'd0, exValid}, 32'd1);
    end
    hold = 0;

    // Flush wins over hold and load-use
    setId(32'h150, 1, 2, 0, 0, 4, 1, 16'h0);
    applyStimulus();
    setId(32'h154, 4, 0, 1, 0, 9, 0, 16'h0);
    hold = 1; flush = 1;
    #1 checkOutput("flush_stall", {31'd0, idStall}, 32'd0);
    applyStimulus();
    checkOutput("flush_valid", {31'd0, exValid}, 32'd0);
    checkOutput("flush_cnt", stallCycles, 32'd1);

    // Reset during an active load-use stall
    idle();
    setId(32'h160, 1, 2, 0, 0, 4, 1, 16'h0);
    applyStimulus();
    setId(32'h164, 4, 0, 1, 0, 9, 0, 16'h0);
    #1 checkOutput("rstmid_stall", {31'd0, idStall}, 32'd1);
    rst = 1;
    applyStimulus();
    rst = 0;
    #1 checkAllZero("rstmid");
    idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (!lastStall) begin
        setId($urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4),
              16'($urandom()));
        idValid = ($urandom_range(0, 99) < 85);
      end
      memEn = 1'($urandom_range(0, 1)); memRd = 5'($urandom_range(0, 7)); memData = $urandom();
      wbEn  = 1'($urandom_range(0, 1)); wbRd  = 5'($urandom_range(0, 7)); wbData  = $urandom();
      hold  = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 8);
      rst   = ($urandom_range(0, 99) < 2);
      applyStimulus();
    end

    idle();
    applyStimulus();
    applyStimulus();
    checkOutput("sbDrained", sbQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
